// File: rtl/mult_arbiter.sv
// Round-robin front end that shares one sequential 8x8 multiplier among N_REQ clients.
// Winner operands are latched and held for the multiplier; the product is returned with the client id.
module mult_arbiter #(
    parameter int  N_REQ       = 4,
    parameter int  TIMEOUT     = 32,
    parameter int  ZERO_BYPASS = 1,
    localparam int ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_mcand,
    input  logic [8*N_REQ-1:0] req_mplier,
    output logic [N_REQ-1:0]   gnt,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [15:0]        rsp_product,
    output logic               rsp_err,
    output logic               mul_load,
    output logic [7:0]         mul_mcand,
    output logic [7:0]         mul_mplier,
    input  logic               mul_done,
    input  logic [15:0]        mul_product
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              mul_load_q, mul_load_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [15:0]       rsp_product_q, rsp_product_d;
    logic              rsp_err_q, rsp_err_d;
    logic [7:0]        mcand_q, mcand_d;
    logic [7:0]        mplier_q, mplier_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

    logic [7:0]        mcand_arr  [N_REQ];
    logic [7:0]        mplier_arr [N_REQ];
    logic [ID_W-1:0]   winner;
    logic              zero_op;

    // Search starts one past the last winner so every client is served in turn.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [ID_W-1:0]  ptr);
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] cand;
        logic            found;
        int              idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            cand = ID_W'(idx);
            if (!found && r[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        return pick;
    endfunction

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            mcand_arr[i]  = req_mcand[8*i +: 8];
            mplier_arr[i] = req_mplier[8*i +: 8];
        end
    end

    assign winner  = rr_pick(req, rr_ptr_q);
    assign zero_op = (ZERO_BYPASS != 0) &&
                     ((mcand_arr[winner] == 8'd0) || (mplier_arr[winner] == 8'd0));

    always_comb begin
        // NOTE: every _d takes its hold value first so no path through the case infers a latch.
        state_d       = state_q;
        gnt_d         = '0;
        mul_load_d    = 1'b0;
        rsp_id_d      = rsp_id_q;
        rsp_product_d = rsp_product_q;
        rsp_err_d     = rsp_err_q;
        mcand_d       = mcand_q;
        mplier_d      = mplier_q;
        rr_ptr_d      = rr_ptr_q;
        wait_cnt_d    = wait_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    rsp_id_d        = winner;
                    mcand_d         = mcand_arr[winner];
                    mplier_d        = mplier_arr[winner];
                    rr_ptr_d        = winner;
                    rsp_err_d       = 1'b0;
                    gnt_d[winner]   = 1'b1;
                    if (zero_op) begin
                        rsp_product_d = 16'd0;
                        state_d       = S_RESP;
                    end else begin
                        mul_load_d = 1'b1;
                        state_d    = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                // mul_done may still be high from the previous operation here.
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (mul_done) begin
                    rsp_product_d = mul_product;
                    rsp_err_d     = 1'b0;
                    state_d       = S_RESP;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_product_d = 16'd0;
                    rsp_err_d     = 1'b1;
                    state_d       = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            gnt_q         <= '0;
            mul_load_q    <= 1'b0;
            rsp_id_q      <= '0;
            rsp_product_q <= 16'd0;
            rsp_err_q     <= 1'b0;
            mcand_q       <= 8'd0;
            mplier_q      <= 8'd0;
            rr_ptr_q      <= ID_W'(N_REQ - 1);
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            mul_load_q    <= mul_load_d;
            rsp_id_q      <= rsp_id_d;
            rsp_product_q <= rsp_product_d;
            rsp_err_q     <= rsp_err_d;
            mcand_q       <= mcand_d;
            mplier_q      <= mplier_d;
            rr_ptr_q      <= rr_ptr_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign gnt         = gnt_q;
    assign mul_load    = mul_load_q;
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_id      = rsp_id_q;
    assign rsp_product = rsp_product_q;
    assign rsp_err     = rsp_err_q;
    assign mul_mcand   = mcand_q;
    assign mul_mplier  = mplier_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed requests, scoreboard of expected responses, behavioural multiplier.
module tb_mult_arbiter;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 32;
    localparam int ID_W    = 2;

    logic                clock = 1'b0;
    logic                reset_n;
    logic [N_REQ-1:0]    req;
    logic [8*N_REQ-1:0]  req_mcand;
    logic [8*N_REQ-1:0]  req_mplier;
    logic [N_REQ-1:0]    gnt;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic [15:0]         rsp_product;
    logic                rsp_err;
    logic                mul_load;
    logic [7:0]          mul_mcand;
    logic [7:0]          mul_mplier;
    logic                mul_done;
    logic [15:0]         mul_product;

    logic                mul_stall;
    int                  load_cnt = 0;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [15:0]     product;
        logic            err;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mult_arbiter #(
        .N_REQ      (N_REQ),
        .TIMEOUT    (TIMEOUT),
        .ZERO_BYPASS(1)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req        (req),
        .req_mcand  (req_mcand),
        .req_mplier (req_mplier),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_product(rsp_product),
        .rsp_err    (rsp_err),
        .mul_load   (mul_load),
        .mul_mcand  (mul_mcand),
        .mul_mplier (mul_mplier),
        .mul_done   (mul_done),
        .mul_product(mul_product)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int id, input logic [15:0] prod, input logic err);
        rsp_t e;
        e.id      = ID_W'(id);
        e.product = prod;
        e.err     = err;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b);
        req_mcand[8*id +: 8]  = a;
        req_mplier[8*id +: 8] = b;
        req[id]               = 1'b1;
    endtask

    task automatic wait_gnt(input int id);
        for (int c = 0; c < 60; c++) begin
            @(posedge clock); #1;
            if (gnt[id]) break;
        end
        check($sformatf("gnt%0d_seen", id), 32'(gnt[id]), 32'd1);
    endtask

    task automatic wait_valid();
        for (int c = 0; c < 60; c++) begin
            @(posedge clock); #1;
            if (rsp_valid) break;
        end
        check("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    endtask

    task automatic drain();
        for (int c = 0; c < 200; c++) begin
            if (exp_q.size() == 0 && !rsp_valid) break;
            @(posedge clock); #1;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
    endtask

    // Behavioural multiplier: done drops two cycles after load, result a few cycles later.
    initial begin
        int cnt;
        int drop_cnt;
        logic busy;
        mul_done    = 1'b0;
        mul_product = 16'd0;
        busy        = 1'b0;
        cnt         = 0;
        drop_cnt    = 0;
        forever begin
            @(posedge clock); #1;
            if (mul_load) begin
                busy     = 1'b1;
                cnt      = 0;
                drop_cnt = 2;
            end else begin
                if (drop_cnt > 0) begin
                    drop_cnt--;
                    if (drop_cnt == 0) mul_done = 1'b0;
                end
                if (busy && !mul_stall && drop_cnt == 0) begin
                    cnt++;
                    if (cnt == 3) begin
                        mul_done    = 1'b1;
                        mul_product = 16'(mul_mcand) * 16'(mul_mplier);
                        busy        = 1'b0;
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clock);
        if (mul_load) load_cnt++;
    end

    // Scoreboard monitor: every accepted response is compared with the oldest expectation.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clock);
            if (reset_n && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    check("rsp_product", 32'(rsp_product), 32'(e.product));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          order [5] = '{0, 1, 2, 3, 0};
        int          lc0;
        logic [18:0] snap;

        reset_n    = 1'b0;
        req        = '0;
        req_mcand  = '0;
        req_mplier = '0;
        rsp_ready  = 1'b1;
        mul_stall  = 1'b0;

        repeat (2) @(posedge clock); #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_mul_load", 32'(mul_load), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_product", 32'(rsp_product), 32'd0);
        check("rst_mul_mcand", 32'(mul_mcand), 32'd0);
        check("rst_mul_mplier", 32'(mul_mplier), 32'd0);
        @(negedge clock) reset_n = 1'b1;

        // Single request, 13*11.
        @(posedge clock); #1;
        push_exp(0, 16'd143, 1'b0);
        set_req(0, 8'd13, 8'd11);
        @(posedge clock); #1;
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_mul_load", 32'(mul_load), 32'd1);
        check("t1_mul_mcand", 32'(mul_mcand), 32'd13);
        check("t1_mul_mplier", 32'(mul_mplier), 32'd11);
        req[0] = 1'b0;
        @(posedge clock); #1;
        check("t1_gnt_pulse", 32'(gnt), 32'd0);
        check("t1_load_pulse", 32'(mul_load), 32'd0);
        drain();

        // All four held from reset: grant order 0,1,2,3,0.
        do_reset();
        set_req(0, 8'd255, 8'd255);
        set_req(1, 8'd200, 8'd3);
        set_req(2, 8'd17, 8'd19);
        set_req(3, 8'd128, 8'd2);
        push_exp(0, 16'd65025, 1'b0);
        push_exp(1, 16'd600, 1'b0);
        push_exp(2, 16'd323, 1'b0);
        push_exp(3, 16'd256, 1'b0);
        push_exp(0, 16'd65025, 1'b0);
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 60; c++) begin
                @(posedge clock); #1;
                if (gnt != '0) break;
            end
            check($sformatf("rr_grant_%0d", k), 32'(gnt), 32'd1 << order[k]);
            if (k == 4) req = '0;
        end
        drain();

        // Zero operand bypass on client 2.
        @(posedge clock); #1;
        push_exp(2, 16'd0, 1'b0);
        lc0 = load_cnt;
        set_req(2, 8'd0, 8'd77);
        @(posedge clock); #1;
        check("t3_gnt", 32'(gnt), 32'h4);
        check("t3_rsp_valid", 32'(rsp_valid), 32'd1);
        req = '0;
        drain();
        check("t3_no_mul_load", 32'(load_cnt), 32'(lc0));

        // Multiplier never finishes: timeout exactly TIMEOUT cycles after WAIT entry.
        mul_stall = 1'b1;
        @(posedge clock); #1;
        push_exp(1, 16'd0, 1'b1);
        set_req(1, 8'd5, 8'd6);
        wait_gnt(1);
        req[1] = 1'b0;
        repeat (TIMEOUT + 1) @(posedge clock);
        #1;
        check("t4_valid_early", 32'(rsp_valid), 32'd0);
        @(posedge clock); #1;
        check("t4_valid_at_timeout", 32'(rsp_valid), 32'd1);
        check("t4_err_flag", 32'(rsp_err), 32'd1);
        drain();
        mul_stall = 1'b0;

        // Consumer back-pressure with another client pending.
        rsp_ready = 1'b0;
        @(posedge clock); #1;
        push_exp(0, 16'd63, 1'b0);
        set_req(0, 8'd7, 8'd9);
        wait_gnt(0);
        req[0] = 1'b0;
        wait_valid();
        push_exp(1, 16'd12, 1'b0);
        set_req(1, 8'd3, 8'd4);
        snap = {rsp_id, rsp_product, rsp_err};
        for (int c = 0; c < 5; c++) begin
            @(posedge clock); #1;
            check("t5_hold_fields", 32'({rsp_valid, rsp_id, rsp_product, rsp_err}),
                  32'({1'b1, snap}));
            check("t5_no_gnt", 32'(gnt), 32'd0);
        end
        rsp_ready = 1'b1;
        wait_gnt(1);
        req[1] = 1'b0;
        drain();

        // Reset while waiting on the multiplier.
        mul_stall = 1'b1;
        @(posedge clock); #1;
        set_req(3, 8'd9, 8'd9);
        wait_gnt(3);
        req[3] = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("t6_gnt", 32'(gnt), 32'd0);
        check("t6_mul_load", 32'(mul_load), 32'd0);
        check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t6_rsp_fields", 32'({rsp_id, rsp_product, rsp_err}), 32'd0);
        check("t6_mul_operands", 32'({mul_mcand, mul_mplier}), 32'd0);
        @(negedge clock) reset_n = 1'b1;
        mul_stall = 1'b0;
        @(posedge clock); #1;
        push_exp(3, 16'd120, 1'b0);
        set_req(3, 8'd10, 8'd12);
        wait_gnt(3);
        check("t6_load_after_reset", 32'(mul_load), 32'd1);
        req[3] = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
